// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: owns the write and read ports of a 2**ADDR_W x DATA_W
// dual-port RAM. Two requesters share the write port through a req/gnt
// handshake, a CLEAR sequence zero-fills the whole RAM, and the read address
// is advanced by a free-running, tick-paced scanner.
// Optional feature macro: ARB_FIXED_PRIO_EN (fixed A-over-B priority instead
// of round-robin).
`timescale 1ns/1ps

module ram_access_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int TICK_DIV = 10
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ_A,
    input  logic [ADDR_W-1:0] ADDR_A,
    input  logic [DATA_W-1:0] DATA_A,
    output logic              GNT_A,
    input  logic              REQ_B,
    input  logic [ADDR_W-1:0] ADDR_B,
    input  logic [DATA_W-1:0] DATA_B,
    output logic              GNT_B,
    input  logic              CLEAR_REQ,
    output logic              CLEAR_DONE,
    output logic              BUSY,
    input  logic              SCAN_EN,
    output logic [ADDR_W-1:0] WRADDRESS,
    output logic [DATA_W-1:0] WDATA,
    output logic              WREN,
    output logic [ADDR_W-1:0] RDADDRESS
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
    logic              last_b_reg, last_b_next;    // 1: B was granted most recently
    logic [1:0]        gnt_reg, gnt_next;          // bit 0 = A, bit 1 = B
    logic              wren_reg, wren_next;
    logic [ADDR_W-1:0] waddr_reg, waddr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic              done_reg, done_next;
    logic [TICK_W-1:0] tick_reg;
    logic [ADDR_W-1:0] rdaddr_reg;

    logic [1:0]        req_vec;
    logic [1:0]        eligible;
    logic              pick_a;
    logic              pick_b;

    assign req_vec = {REQ_B, REQ_A};

    // A requester whose grant is on the port right now is still showing its
    // old REQ; mask it so one request never yields two grants.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_elig
            assign eligible[gi] = req_vec[gi] & ~gnt_reg[gi];
        end
    endgenerate

    // Winner selection among eligible requesters
`ifdef ARB_FIXED_PRIO_EN
    // A owns the port whenever it is asserting REQ; B only gets through once
    // A has let go, so a continuously requesting A yields A,-,A,-,...
    assign pick_a = eligible[0];
    assign pick_b = eligible[1] & ~REQ_A;
`else
    // Round-robin: on a tie the requester not granted last time wins.
    assign pick_a = eligible[0] & (~eligible[1] | last_b_reg);
    assign pick_b = eligible[1] & (~eligible[0] | ~last_b_reg);
`endif

    // Next-state and next-output logic for the IDLE/CLEAR controller
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        last_b_next  = last_b_reg;
        gnt_next     = 2'b00;
        wren_next    = 1'b0;
        waddr_next   = waddr_reg;
        wdata_next   = wdata_reg;
        done_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (CLEAR_REQ) begin
                    // Clear takes precedence; pending requests simply wait.
                    state_next   = ST_CLEAR;
                    clr_cnt_next = '0;
                end else if (pick_a) begin
                    gnt_next    = 2'b01;
                    wren_next   = 1'b1;
                    waddr_next  = ADDR_A;
                    wdata_next  = DATA_A;
                    last_b_next = 1'b0;
                end else if (pick_b) begin
                    gnt_next    = 2'b10;
                    wren_next   = 1'b1;
                    waddr_next  = ADDR_B;
                    wdata_next  = DATA_B;
                    last_b_next = 1'b1;
                end
            end
            ST_CLEAR: begin
                wren_next    = 1'b1;
                waddr_next   = clr_cnt_reg;
                wdata_next   = '0;
                clr_cnt_next = clr_cnt_reg + 1'b1;
                if (clr_cnt_reg == '1) begin
                    // Done pulse coincides with the top-address write.
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Controller state and registered RAM write-port outputs
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_reg   <= ST_IDLE;
            clr_cnt_reg <= '0;
            last_b_reg  <= 1'b1;
            gnt_reg     <= 2'b00;
            wren_reg    <= 1'b0;
            waddr_reg   <= '0;
            wdata_reg   <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
            last_b_reg  <= last_b_next;
            gnt_reg     <= gnt_next;
            wren_reg    <= wren_next;
            waddr_reg   <= waddr_next;
            wdata_reg   <= wdata_next;
            done_reg    <= done_next;
        end
    end

    // Read-address scanner: one step every TICK_DIV enabled cycles, wraps at top
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            tick_reg   <= '0;
            rdaddr_reg <= '0;
        end else if (!SCAN_EN) begin
            tick_reg   <= '0;
        end else if (tick_reg == TICK_W'(TICK_DIV - 1)) begin
            tick_reg   <= '0;
            rdaddr_reg <= rdaddr_reg + 1'b1;
        end else begin
            tick_reg   <= tick_reg + 1'b1;
        end
    end

    assign GNT_A      = gnt_reg[0];
    assign GNT_B      = gnt_reg[1];
    assign WREN       = wren_reg;
    assign WRADDRESS  = waddr_reg;
    assign WDATA      = wdata_reg;
    assign CLEAR_DONE = done_reg;
    assign BUSY       = (state_reg == ST_CLEAR);
    assign RDADDRESS  = rdaddr_reg;

endmodule
